// File: rtl/est_stream_buf.sv
// ============================================================================
// Module   : est_stream_buf
// Brief    : Tags readout estimates and reservoir inputs with a wrapping sample
//            index and buffers them in a DEPTH-record FIFO for a valid/ready
//            consumer, with drop accounting. Define ESN_ERR_ACCUM_EN to add a
//            saturating |est - target| accumulator on err_acc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module est_stream_buf #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_est,
  input  logic [15:0]              in_u,
  input  logic [31:0]              in_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W+47:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic [47:0]              err_acc,
  input  logic                     clr_stats
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REC_W = IDX_W + 48;
  localparam logic [LVL_W-1:0] C_DEPTH = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] C_ONE   = LVL_W'(1);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_out_valid;
  logic [REC_W-1:0]   r_out_data;
  logic               r_overflow;
  logic [15:0]        r_drop_cnt;

  // Sized to the pointer range so natural wrap is safe; with the output
  // register holding one record, at most DEPTH-1 slots are ever occupied.
  logic [REC_W-1:0]   r_mem [DEPTH];

  logic               w_pop;
  logic               w_space;
  logic               w_push;
  logic               w_drop;
  logic [REC_W-1:0]   w_rec;
  logic [LVL_W-1:0]   w_ram_cnt;
  logic               w_ram_nonempty;
  logic               w_out_free;
  logic               w_ram_rd;
  logic               w_ram_wr;
  logic [LVL_W-1:0]   w_level_nxt;

  always_comb begin
    w_pop          = r_out_valid & out_ready;
    w_space        = (r_state != ST_FULL) | w_pop;
    w_push         = in_valid & w_space;
    w_drop         = in_valid & ~w_space;
    w_rec          = {r_idx, in_u, in_est};
    w_ram_cnt      = r_level - LVL_W'(r_out_valid);
    w_ram_nonempty = (w_ram_cnt != '0);
    w_out_free     = ~r_out_valid | w_pop;
    w_ram_rd       = w_out_free & w_ram_nonempty;
    // A push bypasses the RAM only when the output register frees up and
    // nothing older is waiting behind it.
    w_ram_wr       = w_push & ~(w_out_free & ~w_ram_nonempty);
    w_level_nxt    = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + C_ONE;
      2'b01:   w_level_nxt = r_level - C_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_ram_wr && !rst) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_idx       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (in_valid) begin
        r_idx <= r_idx + IDX_W'(1);
      end

      if (w_ram_rd) begin
        r_out_data  <= r_mem[r_rd_ptr];
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
      end else if (w_out_free) begin
        if (w_push) begin
          r_out_data  <= w_rec;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end

      if (w_ram_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end

      r_level <= w_level_nxt;
      if (w_level_nxt == '0) begin
        r_state <= ST_EMPTY;
      end else if (w_level_nxt == C_DEPTH) begin
        r_state <= ST_FULL;
      end else begin
        r_state <= ST_ACTIVE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

`ifdef ESN_ERR_ACCUM_EN
  logic [47:0]        r_err_acc;
  logic signed [32:0] w_diff;
  logic [32:0]        w_mag;
  logic [48:0]        w_sum;

  always_comb begin
    // Sign-extend to 33 bits so the difference of any two 32-bit values fits.
    w_diff = $signed({in_est[31], in_est}) - $signed({in_target[31], in_target});
    w_mag  = w_diff[32] ? 33'(-w_diff) : 33'(w_diff);
    w_sum  = {1'b0, r_err_acc} + 49'(w_mag);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      r_err_acc <= '0;
    end else if (in_valid) begin
      r_err_acc <= w_sum[48] ? {48{1'b1}} : w_sum[47:0];
    end
  end

  assign err_acc = r_err_acc;
`else
  logic w_unused_target;
  assign w_unused_target = ^in_target;
  assign err_acc         = '0;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_est_stream_buf.sv
// ============================================================================
// Module   : tb_est_stream_buf
// Brief    : Directed self-checking bench for est_stream_buf (DEPTH=16,
//            IDX_W=16); err_acc expectations follow ESN_ERR_ACCUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_est_stream_buf;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_est;
  logic [15:0] in_u;
  logic [31:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [47:0] err_acc;
  logic        clr_stats;

  int checks;
  int errors;
  int max_level;

  est_stream_buf #(.DEPTH(16), .IDX_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_est    (in_est),
    .in_u      (in_u),
    .in_target (in_target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .err_acc   (err_acc),
    .clr_stats (clr_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rec(input logic [15:0] i, input logic [15:0] u,
                                      input logic [31:0] e);
    return {i, u, e};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    max_level = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_est    = '0;
    in_u      = '0;
    in_target = '0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  out_data,       64'd0);
    check("rst_level",     64'(level),     64'd0);
    check("rst_overflow",  64'(overflow),  64'd0);
    check("rst_drop_cnt",  64'(drop_cnt),  64'd0);
    check("rst_err_acc",   64'(err_acc),   64'd0);

    // Single sample with consumer ready: one-cycle latency, then popped.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_est    = 32'h0001_0000;
    in_u      = 16'h1234;
    tick();
    in_valid = 1'b0;
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_data",  out_data, rec(16'h0000, 16'h1234, 32'h0001_0000));
    check("lat_level", 64'(level), 64'd1);
    tick();
    check("pop_level", 64'(level), 64'd0);
    check("pop_valid", 64'(out_valid), 64'd0);

    // Fill to 16 and drop 3 with consumer stalled.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      in_valid = 1'b1;
      in_est   = 32'h100 + 32'(i);
      in_u     = 16'h10 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    check("full_level",    64'(level),    64'd16);
    check("full_drop_cnt", 64'(drop_cnt), 64'd3);
    check("full_overflow", 64'(overflow), 64'd1);
    check("full_head",     out_data,      rec(16'd0, 16'h10, 32'h100));
    tick();
    check("stall_hold",    out_data,      rec(16'd0, 16'h10, 32'h100));

    // Push and pop together while FULL.
    in_valid  = 1'b1;
    in_est    = 32'hAA;
    in_u      = 16'hAA;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pp_level",    64'(level),    64'd16);
    check("pp_drop_cnt", 64'(drop_cnt), 64'd3);
    check("pp_head",     out_data,      rec(16'd1, 16'h11, 32'h101));
    for (int j = 0; j < 16; j++) begin
      logic [63:0] exp_rec;
      exp_rec = (j < 15) ? rec(16'(j + 1), 16'h10 + 16'(j + 1), 32'h100 + 32'(j + 1))
                         : rec(16'd19, 16'hAA, 32'hAA);
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_data",  out_data,       exp_rec);
      tick();
    end
    check("drain_level", 64'(level),     64'd0);
    check("drain_empty", 64'(out_valid), 64'd0);

    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_overflow", 64'(overflow), 64'd0);
    check("clr_drop_cnt", 64'(drop_cnt), 64'd0);

    // Index wrap: advance to 0xFFFE with the consumer always ready.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      in_est = 32'(i);
      tick();
      if (int'(level) > max_level) max_level = int'(level);
    end
    in_valid = 1'b0;
    tick();
    check("stream_max_level", 64'(max_level), 64'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_est   = 32'(i + 1);
      in_u     = 16'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    check("wrap_level", 64'(level), 64'd3);
    check("wrap_fffe",  out_data, rec(16'hFFFE, 16'd1, 32'd1));
    out_ready = 1'b1;
    tick();
    check("wrap_ffff",  out_data, rec(16'hFFFF, 16'd2, 32'd2));
    tick();
    check("wrap_0000",  out_data, rec(16'h0000, 16'd3, 32'd3));
    tick();

    // Mid-operation reset with an in_valid held during reset.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_est   = 32'h50 + 32'(i);
      in_u     = 16'h5;
      tick();
    end
    check("mid_level", 64'(level), 64'd5);
    rst      = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_valid",    64'(out_valid), 64'd0);
    check("mid_rst_level",    64'(level),     64'd0);
    check("mid_rst_drop_cnt", 64'(drop_cnt),  64'd0);
    in_valid = 1'b1;
    in_est   = 32'h77;
    in_u     = 16'h7;
    tick();
    in_valid = 1'b0;
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_idx0",  out_data, rec(16'd0, 16'h7, 32'h77));

    // Error accumulator: |-5-7| = 12, then +|100-40| = 72, then cleared.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_est    = 32'hFFFF_FFFB;
    in_target = 32'd7;
    tick();
    in_valid = 1'b0;
    tick();
`ifdef ESN_ERR_ACCUM_EN
    check("err_first", 64'(err_acc), 64'd12);
`else
    check("err_first", 64'(err_acc), 64'd0);
`endif
    in_valid  = 1'b1;
    in_est    = 32'd100;
    in_target = 32'd40;
    tick();
    in_valid = 1'b0;
    tick();
`ifdef ESN_ERR_ACCUM_EN
    check("err_second", 64'(err_acc), 64'd72);
`else
    check("err_second", 64'(err_acc), 64'd0);
`endif
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("err_clr", 64'(err_acc), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
